// File: rtl/line_buffer_ctrl.sv
// Sequencer for a rotating KER_SIZE-bank line buffer. Each accepted pixel is written
// into the current row bank while the other banks are read at the same column.
module line_buffer_ctrl #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         cfg_cols,
  input  logic [15:0]         cfg_rows,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic [AW-1:0]       sram_a,
  output logic [KER_SIZE-1:0] sram_wen,
  output logic [KER_SIZE-1:0] sram_ren,
  output logic [DW-1:0]       sram_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_cur,
  output logic [AW-1:0]       out_col,
  output logic [15:0]         out_row
);

  localparam int BW = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          state;
  logic [AW:0]         cols_q;
  logic [15:0]         rows_q;
  logic [AW-1:0]       col;
  logic [15:0]         row;
  logic [BW-1:0]       bank;
  logic [KER_SIZE-1:0] bank_oh;
  logic                accept;
  logic                col_last;
  logic                row_last;
  logic                win_en;
  logic                cfg_bad;

  assign bank_oh  = KER_SIZE'(1) << bank;
  // Windows exist only once KER_SIZE-1 earlier rows sit in the other banks.
  assign win_en   = (row >= 16'(KER_SIZE - 1));
  assign col_last = ({1'b0, col} == (cols_q - 1'b1));
  assign row_last = (row == (rows_q - 16'd1));
  assign cfg_bad  = (cfg_cols == '0) || (cfg_cols > (AW+1)'(NW)) || (cfg_rows == 16'd0);

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sram_a   = col;
  assign sram_d   = in_data;
  assign sram_wen = accept ? bank_oh : '0;
  assign sram_ren = (accept && win_en) ? ~bank_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cols_q  <= '0;
      rows_q  <= '0;
      col     <= '0;
      row     <= '0;
      bank    <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cols_q <= cfg_cols;
              rows_q <= cfg_rows;
              col    <= '0;
              row    <= '0;
              bank   <= '0;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_last) begin
              col  <= '0;
              row  <= row + 16'd1;
              bank <= (bank == BW'(KER_SIZE - 1)) ? '0 : bank + 1'b1;
              if (row_last) state <= S_DRAIN;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A new window replaces the presented one in the same cycle, so streaming has no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cur   <= '0;
      out_col   <= '0;
      out_row   <= '0;
    end else if (accept && win_en) begin
      out_valid <= 1'b1;
      out_cur   <= in_data;
      out_col   <= col;
      out_row   <= row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
